// File: rtl/cnn_pkg.sv
// Shared constants for the CNN datapath blocks: default element format and
// the convolution engine's FSM state encoding.
package cnn_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int FRAC_W_DEF = 11;

  // Headroom bits above a full-precision product; covers a 5x5 sum plus bias
  localparam int ACC_GUARD_W = 5;

  typedef logic [1:0] conv_state_t;

  localparam conv_state_t ST_IDLE  = 2'd0;
  localparam conv_state_t ST_ACCUM = 2'd1;
  localparam conv_state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/conv_row_mac.sv
// Combinational multiply-accumulate of one kernel row: sum of K signed
// DATA_W x DATA_W products, sign-extended to the accumulator width.
module conv_row_mac
  import cnn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int K      = 5,
  parameter int ACC_W  = 2 * DATA_W + ACC_GUARD_W
) (
  input  logic [K-1:0][DATA_W-1:0] win_row,
  input  logic [K-1:0][DATA_W-1:0] filt_row,
  output logic [ACC_W-1:0]         row_sum
);

  logic signed [2*DATA_W-1:0] prod_s [K];

  // Full-precision products, extended and summed across the row
  always_comb begin
    row_sum = {ACC_W{1'b0}};
    for (int c = 0; c < K; c++) begin
      prod_s[c] = $signed(win_row[c]) * $signed(filt_row[c]);
      row_sum   = row_sum + {{(ACC_W - 2*DATA_W){prod_s[c][2*DATA_W-1]}}, prod_s[c]};
    end
  end

endmodule

// File: rtl/conv_engine.sv
// KxK fixed-point convolution engine: accepts one patch/kernel pair, sums one
// kernel row per cycle, then rounds down, saturates and optionally ReLUs.
module conv_engine
  import cnn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int K      = 5
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [K-1:0][K-1:0][DATA_W-1:0]  window,
  input  logic [K-1:0][K-1:0][DATA_W-1:0]  filter,
  input  logic [DATA_W-1:0]                bias,
  input  logic                             relu_en,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_W-1:0]                conv_result,
  output logic                             sat
);

  localparam int ACC_W = 2 * DATA_W + ACC_GUARD_W;
  localparam int ROW_W = $clog2(K);

  localparam logic signed [ACC_W-1:0] RES_MAX =
    {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] RES_MIN =
    {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

  conv_state_t                      state_r, state_next_s;
  logic [ROW_W-1:0]                 row_r;
  logic [ACC_W-1:0]                 acc_r;
  logic [K-1:0][K-1:0][DATA_W-1:0]  win_r, filt_r;
  logic [DATA_W-1:0]                bias_r;
  logic                             relu_r;
  logic                             in_ready_r, out_valid_r, sat_r;
  logic [DATA_W-1:0]                result_r;

  logic [ACC_W-1:0]                 row_sum_s;
  logic signed [ACC_W-1:0]          bias_ext_s, sum_s, shifted_s;
  logic [DATA_W-1:0]                res_s;
  logic                             sat_s;

  conv_row_mac #(
    .DATA_W (DATA_W),
    .K      (K),
    .ACC_W  (ACC_W)
  ) u_row_mac (
    .win_row  (win_r[row_r]),
    .filt_row (filt_r[row_r]),
    .row_sum  (row_sum_s)
  );

  // Next-state decode
  always_comb begin
    state_next_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (in_valid && in_ready_r) state_next_s = ST_ACCUM;
        else                        state_next_s = ST_IDLE;
      end
      ST_ACCUM: begin
        if (row_r == ROW_W'(K - 1)) state_next_s = ST_DONE;
        else                        state_next_s = ST_ACCUM;
      end
      ST_DONE: begin
        if (out_valid_r && out_ready) state_next_s = ST_IDLE;
        else                          state_next_s = ST_DONE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Bias alignment, floor shift (arithmetic >>>) and clamp / ReLU
  always_comb begin
    bias_ext_s = {{(ACC_W - DATA_W){bias_r[DATA_W-1]}}, bias_r};
    sum_s      = $signed(acc_r) + (bias_ext_s <<< FRAC_W);
    shifted_s  = sum_s >>> FRAC_W;
    res_s      = shifted_s[DATA_W-1:0];
    sat_s      = 1'b0;
    if (relu_r && shifted_s[ACC_W-1]) begin
      res_s = {DATA_W{1'b0}};
      sat_s = 1'b0;
    end else if (shifted_s > RES_MAX) begin
      res_s = RES_MAX[DATA_W-1:0];
      sat_s = 1'b1;
    end else if (shifted_s < RES_MIN) begin
      res_s = RES_MIN[DATA_W-1:0];
      sat_s = 1'b1;
    end else begin
      res_s = shifted_s[DATA_W-1:0];
      sat_s = 1'b0;
    end
  end

  // FSM, operand capture, row accumulation and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      row_r       <= {ROW_W{1'b0}};
      acc_r       <= {ACC_W{1'b0}};
      win_r       <= '{default: {DATA_W{1'b0}}};
      filt_r      <= '{default: {DATA_W{1'b0}}};
      bias_r      <= {DATA_W{1'b0}};
      relu_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= {DATA_W{1'b0}};
      sat_r       <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      in_ready_r <= (state_next_s == ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (in_valid && in_ready_r) begin
            win_r  <= window;
            filt_r <= filter;
            bias_r <= bias;
            relu_r <= relu_en;
            acc_r  <= {ACC_W{1'b0}};
            row_r  <= {ROW_W{1'b0}};
          end
        end
        ST_ACCUM: begin
          acc_r <= acc_r + row_sum_s;
          row_r <= row_r + ROW_W'(1);
        end
        ST_DONE: begin
          // First DONE cycle registers the result; it then holds until taken
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
            result_r    <= res_s;
            sat_r       <= sat_s;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign conv_result = result_r;
  assign sat         = sat_r;

endmodule

// File: tb/tb_conv_engine.sv
// Bench for conv_engine: directed corner cases plus random operands on a K=5
// and a K=3 instance, compared against an arithmetic reference model.
module tb_conv_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [4:0][4:0][15:0] w_t, f_t;
  logic [2:0][2:0][15:0] w3_s, f3_s;
  logic [15:0] b_t;
  logic relu_t;

  logic iv5, ir5, ov5, or5, sat5;
  logic [15:0] res5;
  logic iv3, ir3, ov3, or3, sat3;
  logic [15:0] res3;

  int total = 0;
  int bad   = 0;

  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        w3_s[r][c] = w_t[r][c];
        f3_s[r][c] = f_t[r][c];
      end
  end

  conv_engine #(.DATA_W(16), .FRAC_W(11), .K(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .window(w_t), .filter(f_t), .bias(b_t),
    .relu_en(relu_t), .in_valid(iv5), .in_ready(ir5), .out_valid(ov5),
    .out_ready(or5), .conv_result(res5), .sat(sat5)
  );

  conv_engine #(.DATA_W(16), .FRAC_W(11), .K(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .window(w3_s), .filter(f3_s), .bias(b_t),
    .relu_en(relu_t), .in_valid(iv3), .in_ready(ir3), .out_valid(ov3),
    .out_ready(or3), .conv_result(res3), .sat(sat3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer dot product, bias scaled by 2^11, floor divide, clamp
  function automatic void model(input int k, input logic [4:0][4:0][15:0] w,
                                input logic [4:0][4:0][15:0] f, input logic [15:0] b,
                                input logic relu, output logic [15:0] r, output logic s);
    longint acc, v;
    acc = 0;
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++)
        acc += longint'($signed(w[i][j])) * longint'($signed(f[i][j]));
    acc += longint'($signed(b)) * 2048;
    v = acc >>> 11;
    if (relu && v < 0) begin r = 16'h0000; s = 1'b0; end
    else if (v > 32767) begin r = 16'h7FFF; s = 1'b1; end
    else if (v < -32768) begin r = 16'h8000; s = 1'b1; end
    else begin r = v[15:0]; s = 1'b0; end
  endfunction

  task automatic set_all(input logic [15:0] wv, input logic [15:0] fv,
                         input logic [15:0] bv, input logic rv);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        w_t[r][c] = wv;
        f_t[r][c] = fv;
      end
    b_t = bv;
    relu_t = rv;
  endtask

  task automatic scramble(input bit full);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        if (full) begin
          w_t[r][c] = 16'($urandom);
          f_t[r][c] = 16'($urandom);
        end else begin
          w_t[r][c] = 16'($urandom_range(0, 8191) - 4096);
          f_t[r][c] = 16'($urandom_range(0, 8191) - 4096);
        end
      end
    b_t = 16'($urandom_range(0, 8191) - 4096);
    relu_t = 1'($urandom_range(0, 1));
  endtask

  task automatic txn(input bit use3, input string tag, input int hold);
    logic [15:0] er;
    logic es;
    int k, lat;
    bit seen;
    k = use3 ? 3 : 5;
    model(k, w_t, f_t, b_t, relu_t, er, es);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if ((use3 ? ir3 : ir5) === 1'b1) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    check({tag, "_in_ready"}, 32'(seen), 32'd1);
    if (use3) iv3 = 1'b1; else iv5 = 1'b1;
    @(posedge clk); #1;
    iv3 = 1'b0; iv5 = 1'b0;
    scramble(1'b1);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if ((use3 ? ov3 : ov5) === 1'b1) begin lat = c; break; end
    end
    check({tag, "_latency"}, 32'(lat), 32'(k + 1));
    check({tag, "_result"}, 32'(use3 ? res3 : res5), 32'(er));
    check({tag, "_sat"}, 32'(use3 ? sat3 : sat5), 32'(es));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "_hold"},
            use3 ? {13'd0, ov3, ir3, sat3, res3} : {13'd0, ov5, ir5, sat5, res5},
            {13'd0, 1'b1, 1'b0, es, er});
    end
    if (use3) or3 = 1'b1; else or5 = 1'b1;
    @(posedge clk); #1;
    or3 = 1'b0; or5 = 1'b0;
    check({tag, "_release"}, use3 ? {30'd0, ov3, ir3} : {30'd0, ov5, ir5}, 32'd1);
  endtask

  initial begin
    bit rose;
    rst_n = 1'b0; iv5 = 1'b0; iv3 = 1'b0; or5 = 1'b0; or3 = 1'b0;
    set_all(16'h0000, 16'h0000, 16'h0000, 1'b0);
    #12;
    check("reset_outs5", {28'd0, ov5, sat5, ir5, |res5}, 32'h2);
    check("reset_outs3", {28'd0, ov3, sat3, ir3, |res3}, 32'h2);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    set_all(16'd2048, 16'd1024, 16'h0000, 1'b0);  txn(1'b0, "pos_k5", 0);
    set_all(16'hF800, 16'd1024, 16'h0000, 1'b0);  txn(1'b0, "neg_k5", 0);
    set_all(16'hF800, 16'd1024, 16'h0000, 1'b1);  txn(1'b0, "neg_relu", 0);
    set_all(16'h7FFF, 16'h7FFF, 16'h0000, 1'b0);  txn(1'b0, "sat_pos", 0);
    set_all(16'h8000, 16'h7FFF, 16'h0000, 1'b0);  txn(1'b0, "sat_neg", 0);
    set_all(16'h8000, 16'h7FFF, 16'h0000, 1'b1);  txn(1'b0, "sat_neg_relu", 0);
    set_all(16'h0000, 16'h0000, 16'd2048, 1'b0);  txn(1'b0, "bias_only", 0);
    set_all(16'd2048, 16'd1024, 16'h0000, 1'b0);  txn(1'b1, "pos_k3", 0);
    set_all(16'd2048, 16'd1024, 16'h0000, 1'b0);  txn(1'b0, "stall_k5", 10);

    // Reset pulse in the middle of accumulation must suppress the result
    set_all(16'd2048, 16'd1024, 16'h0000, 1'b0);
    iv5 = 1'b1;
    @(posedge clk); #1;
    iv5 = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_outs", {29'd0, ov5, sat5, |res5}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    rose = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (ov5 === 1'b1) rose = 1;
    end
    check("midreset_no_valid", 32'(rose), 32'd0);
    check("midreset_ready", 32'(ir5), 32'd1);
    set_all(16'd2048, 16'd1024, 16'd300, 1'b0);  txn(1'b0, "post_reset", 0);

    for (int n = 0; n < 12; n++) begin
      scramble(n % 4 == 3);
      txn(n % 3 == 2, $sformatf("rand%0d", n), n % 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
